// File: rtl/mod_mult_seq.sv
// mod_mult_seq: sequential modular multiplier.
// Computes mult_a * mult_b mod MODULUS by MSB-first interleaved shift-add reduction.
// It processes one bit of the captured multiplier per cycle, then gives a
// one-cycle ready pulse with the result. The result is held until the next load.
module mod_mult_seq #(
    parameter int unsigned             DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]   MODULUS    = DATA_WIDTH'(3329)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] mult_a,
    input  logic [DATA_WIDTH-1:0] mult_b,
    input  logic                  mult_start,
    output logic [DATA_WIDTH-1:0] mult_result,
    output logic                  mult_result_ready,
    output logic                  mult_error,
    output logic                  busy
);

    localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [DATA_WIDTH:0] MOD_EXT = {1'b0, MODULUS};
    localparam logic [CW-1:0] COUNT_INIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] a_reg, a_next;
    logic [DATA_WIDTH-1:0] b_reg, b_next;
    logic [DATA_WIDTH-1:0] acc, acc_next;
    logic [CW-1:0]         counter, counter_next;
    logic [DATA_WIDTH-1:0] result_next;
    logic                  ready_next;
    logic                  error_next;

    logic [DATA_WIDTH:0]   doubled;
    logic [DATA_WIDTH:0]   doubled_red;
    logic [DATA_WIDTH:0]   summed;
    logic [DATA_WIDTH-1:0] step_value;

    // One reduction step: double the accumulator, reduce it, add a if the bit is set, reduce again.
    // Both reductions are needed because acc < MODULUS only bounds 2*acc + a below 3*MODULUS.
    always_comb begin
        doubled     = {acc, 1'b0};
        doubled_red = (doubled >= MOD_EXT) ? (doubled - MOD_EXT) : doubled;
        summed      = doubled_red + (b_reg[counter] ? {1'b0, a_reg} : '0);
        step_value  = DATA_WIDTH'((summed >= MOD_EXT) ? (summed - MOD_EXT) : summed);
    end

    // Next-state and next-register logic. Every value holds unless a transition updates it.
    always_comb begin
        state_next   = state;
        a_next       = a_reg;
        b_next       = b_reg;
        acc_next     = acc;
        counter_next = counter;
        result_next  = mult_result;
        ready_next   = 1'b0;
        error_next   = mult_error;
        unique case (state)
            IDLE: begin
                if (mult_start) begin
                    if (mult_a >= MODULUS) begin
                        result_next = '0;
                        error_next  = 1'b1;
                        ready_next  = 1'b1;
                        state_next  = DONE;
                    end else begin
                        a_next       = mult_a;
                        b_next       = mult_b;
                        acc_next     = '0;
                        counter_next = COUNT_INIT;
                        error_next   = 1'b0;
                        state_next   = RUN;
                    end
                end
            end
            RUN: begin
                acc_next = step_value;
                if (counter == '0) begin
                    result_next = step_value;
                    ready_next  = 1'b1;
                    state_next  = DONE;
                end else begin
                    counter_next = counter - 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers. An asynchronous reset clears everything, so no partial result is ever shown.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            a_reg             <= '0;
            b_reg             <= '0;
            acc               <= '0;
            counter           <= '0;
            mult_result       <= '0;
            mult_result_ready <= 1'b0;
            mult_error        <= 1'b0;
        end else begin
            state             <= state_next;
            a_reg             <= a_next;
            b_reg             <= b_next;
            acc               <= acc_next;
            counter           <= counter_next;
            mult_result       <= result_next;
            mult_result_ready <= ready_next;
            mult_error        <= error_next;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mod_mult_seq.sv
// tb_mod_mult_seq: directed and random self-checking bench for mod_mult_seq.
module tb_mod_mult_seq;

    localparam int DW = 32;

    logic          clock;
    logic          reset_n;
    logic [DW-1:0] mult_a;
    logic [DW-1:0] mult_b;
    logic          mult_start;
    logic [DW-1:0] mult_result;
    logic          mult_result_ready;
    logic          mult_error;
    logic          busy;

    int errors;
    int checks;

    mod_mult_seq #(
        .DATA_WIDTH (DW),
        .MODULUS    (32'd3329)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .mult_a            (mult_a),
        .mult_b            (mult_b),
        .mult_start        (mult_start),
        .mult_result       (mult_result),
        .mult_result_ready (mult_result_ready),
        .mult_error        (mult_error),
        .busy              (busy)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Start one multiply, scramble operands after the start edge, then wait a bounded time for ready.
    // Then check latency, result, error flag, result hold, and the return to IDLE.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp_result, input logic exp_err,
                                 input int exp_latency, input string tag);
        logic [31:0] prev;
        int          edges;
        bit          hold_ok;
        @(negedge clock);
        mult_a     = a;
        mult_b     = b;
        mult_start = 1'b1;
        prev       = mult_result;
        @(posedge clock);
        #1;
        mult_start = 1'b0;
        mult_a     = $urandom;
        mult_b     = $urandom;
        checkOutput({tag, " busy_after_E0"}, 32'(busy), 32'd1);
        edges   = 0;
        hold_ok = 1'b1;
        while (!mult_result_ready && edges < 100) begin
            if (mult_result !== prev) hold_ok = 1'b0;
            @(posedge clock);
            #1;
            edges++;
        end
        checkOutput({tag, " latency"}, 32'(edges), 32'(exp_latency));
        checkOutput({tag, " result"}, mult_result, exp_result);
        checkOutput({tag, " error"}, 32'(mult_error), 32'(exp_err));
        checkOutput({tag, " hold_before_ready"}, 32'(hold_ok), 32'd1);
        @(posedge clock);
        #1;
        checkOutput({tag, " ready_cleared"}, 32'(mult_result_ready), 32'd0);
        checkOutput({tag, " busy_cleared"}, 32'(busy), 32'd0);
        checkOutput({tag, " result_held"}, mult_result, exp_result);
    endtask

    // Directed sequence: reset, corners, mid-run reset, handshake, random.
    initial begin
        int          pulses;
        int          first_edge;
        int          second_edge;
        logic [31:0] first_res;
        logic [31:0] second_res;
        int          n;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] prod;

        errors     = 0;
        checks     = 0;
        reset_n    = 1'b0;
        mult_a     = '0;
        mult_b     = '0;
        mult_start = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset result", mult_result, 32'd0);
        checkOutput("reset ready", 32'(mult_result_ready), 32'd0);
        checkOutput("reset error", 32'(mult_error), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        applyStimulus(32'd1234, 32'd5678, 32'd2436, 1'b0, 32, "typical");

        // Assert reset in the middle of a RUN; the outputs must clear right away.
        @(negedge clock);
        mult_a     = 32'd3328;
        mult_b     = 32'd3328;
        mult_start = 1'b1;
        @(posedge clock);
        #1;
        mult_start = 1'b0;
        repeat (10) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("midrun_reset result", mult_result, 32'd0);
        checkOutput("midrun_reset ready", 32'(mult_result_ready), 32'd0);
        checkOutput("midrun_reset error", 32'(mult_error), 32'd0);
        checkOutput("midrun_reset busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        applyStimulus(32'd5, 32'd7, 32'd35, 1'b0, 32, "after_reset");
        applyStimulus(32'd3328, 32'd3328, 32'd1, 1'b0, 32, "max_operands");
        applyStimulus(32'd0, 32'd1234, 32'd0, 1'b0, 32, "zero_a");
        applyStimulus(32'd1234, 32'd0, 32'd0, 1'b0, 32, "zero_b");
        applyStimulus(32'd2, 32'hFFFF_FFFF, 32'd2704, 1'b0, 32, "wide_b");
        applyStimulus(32'd3329, 32'd9, 32'd0, 1'b1, 0, "out_of_range");
        applyStimulus(32'd1234, 32'd5678, 32'd2436, 1'b0, 32, "error_cleared");

        // Hold start high continuously. b changes right after the first start edge.
        @(negedge clock);
        mult_a      = 32'd1234;
        mult_b      = 32'd5678;
        mult_start  = 1'b1;
        pulses      = 0;
        first_edge  = -1;
        second_edge = -1;
        first_res   = '0;
        second_res  = '0;
        @(posedge clock);
        #1;
        mult_b = 32'd7;
        for (int i = 1; i <= 70; i++) begin
            @(posedge clock);
            #1;
            if (mult_result_ready) begin
                pulses++;
                if (pulses == 1) begin
                    first_edge = i;
                    first_res  = mult_result;
                end else if (pulses == 2) begin
                    second_edge = i;
                    second_res  = mult_result;
                end
            end
        end
        mult_start = 1'b0;
        checkOutput("handshake pulse_count", 32'(pulses), 32'd2);
        checkOutput("handshake first_edge", 32'(first_edge), 32'd32);
        checkOutput("handshake first_result", first_res, 32'd2436);
        checkOutput("handshake second_edge", 32'(second_edge), 32'd66);
        checkOutput("handshake second_result", second_res, 32'd1980);
        n = 0;
        while (busy && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput("handshake drained", 32'(busy), 32'd0);

        // Random operands, compared against a 64-bit reference product.
        for (int k = 0; k < 1000; k++) begin
            ra   = $urandom_range(0, 3328);
            rb   = $urandom;
            prod = (64'(ra) * 64'(rb)) % 64'd3329;
            applyStimulus(ra, rb, prod[31:0], 1'b0, 32, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
